keypad_scanner: RTL and testbench

- Input-side counterpart of the 7-segment display controller: scans a 4x4 active-low key matrix for the calculator front panel.
- Drives one matrix column low at a time and samples the rows through a synchronizer.
- Debounces key press and key release, then reports each accepted key once as a code with a single-cycle valid pulse.
- Output feeds the calculator input/entry logic; mapping of key code to digit or operator is done downstream.

---
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Key matrix and key-event bundle between the keypad scanner and the panel side.
// The master is the scanner: it drives the columns and the key events and reads the rows.
// The slave is the matrix/consumer side.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner for the calculator front panel.
// Drives one column low at a time and samples the rows through a 2-flop synchronizer.
// Press and release are debounced, and each accepted key is reported once as
// {row_idx, col_idx} with a one-cycle key_valid pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SCAN     | rotate the column each tick and look for exactly one row low
//   DEBOUNCE | column frozen; count ticks on which the same row stays low
//   HELD     | key reported; column frozen; count ticks on which all rows are high
module keypad_scanner #(
    parameter int PRESCALE  = 40000,
    parameter int DEB_TICKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DEB_W   = $clog2(DEB_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_TICKS - 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    logic [1:0]         state;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [DEB_W-1:0]   deb_cnt;
    logic [1:0]         col_idx;
    logic [1:0]         row_lat;
    logic [3:0]         rs_meta;
    logic [3:0]         rs;
    logic               single_low;
    logic [1:0]         row_det;
    logic [3:0]         key_code;
    logic               key_valid;
    logic               key_held;

    assign tick         = (presc == PRESC_LAST);
    assign kp.col_n     = ~(4'b0001 << col_idx);
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

    // Bring the asynchronous rows into the clock domain; idle rows read high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= kp.row_n;
            rs      <= rs_meta;
        end
    end

    // Free-running scan-tick prescaler.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Decode exactly one low row; any other pattern is idle or a multi-key press.
    always_comb begin
        single_low = 1'b0;
        row_det    = 2'd0;
        case (rs)
            4'b1110: begin single_low = 1'b1; row_det = 2'd0; end
            4'b1101: begin single_low = 1'b1; row_det = 2'd1; end
            4'b1011: begin single_low = 1'b1; row_det = 2'd2; end
            4'b0111: begin single_low = 1'b1; row_det = 2'd3; end
            default: begin single_low = 1'b0; row_det = 2'd0; end
        endcase
    end

    // Scan / debounce / hold sequencing, advanced only on scan ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            deb_cnt   <= '0;
            col_idx   <= 2'd0;
            row_lat   <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single_low) begin
                            row_lat <= row_det;
                            if (DEB_TICKS == 1) begin
                                key_code  <= {row_det, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= DEB_W'(1);
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs == ~(4'b0001 << row_lat)) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_code  <= {row_lat, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            // Abort without rotating; the next tick resumes the scan.
                            deb_cnt <= '0;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (rs == 4'b1111) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_held <= 1'b0;
                                deb_cnt  <= '0;
                                state    <= SCAN;
                            end else begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                    default: begin
                        deb_cnt  <= '0;
                        key_held <= 1'b0;
                        state    <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with PRESCALE=4, DEB_TICKS=3.
// Cycle index k counts rising edges after the first reset release; all
// expected timings below are hand-derived in terms of k (ticks land on k%4==0).
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    int          k;
    int          n_checks;
    int          n_fail;
    int          pulse_cnt;
    int          dbl_cnt;
    int          last_valid;

    keypad_scanner_if kp_bus();

    keypad_scanner #(
        .PRESCALE (4),
        .DEB_TICKS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp_bus)
    );

    always #5 clk = ~clk;

    // Key matrix: row r is pulled low when key (r,c) is pressed and column c is driven low.
    always_comb begin
        kp_bus.row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp_bus.col_n[c]) kp_bus.row_n[r] = 1'b0;
            end
        end
    end

    // Count key_valid pulses and any back-to-back high cycles.
    initial begin
        pulse_cnt  = 0;
        dbl_cnt    = 0;
        last_valid = 0;
    end
    always @(posedge clk) begin
        #1;
        if (kp_bus.key_valid) begin
            pulse_cnt++;
            if (last_valid != 0) dbl_cnt++;
        end
        last_valid = int'(kp_bus.key_valid);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic wait_to(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        pressed  = 16'h0000;
        reset    = 1'b1;

        // 1. reset and scan
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_col_n",     int'(kp_bus.col_n),     'b1110);
        check_val("rst_key_code",  int'(kp_bus.key_code),  0);
        check_val("rst_key_valid", int'(kp_bus.key_valid), 0);
        check_val("rst_key_held",  int'(kp_bus.key_held),  0);
        reset = 1'b1;
        k = 0;
        wait_to(3);  check_val("scan_k3",  int'(kp_bus.col_n), 'b1110);
        wait_to(4);  check_val("scan_k4",  int'(kp_bus.col_n), 'b1101);
        wait_to(7);  check_val("scan_k7",  int'(kp_bus.col_n), 'b1101);
        wait_to(8);  check_val("scan_k8",  int'(kp_bus.col_n), 'b1011);
        wait_to(12); check_val("scan_k12", int'(kp_bus.col_n), 'b0111);
        wait_to(16); check_val("scan_k16", int'(kp_bus.col_n), 'b1110);

        // 2. press (2,1): seen at col 1 after k=20, detect 24, accept 32
        pressed[2*4+1] = 1'b1;
        wait_to(31); check_val("p21_pre_valid", int'(kp_bus.key_valid), 0);
        wait_to(32);
        check_val("p21_valid", int'(kp_bus.key_valid), 1);
        check_val("p21_code",  int'(kp_bus.key_code),  'b1001);
        check_val("p21_held",  int'(kp_bus.key_held),  1);
        wait_to(33); check_val("p21_valid_1cyc", int'(kp_bus.key_valid), 0);
        wait_to(40); check_val("p21_col_frozen", int'(kp_bus.col_n), 'b1101);
        wait_to(56);
        check_val("p21_held_56",   int'(kp_bus.key_held), 1);
        check_val("p21_col_56",    int'(kp_bus.col_n),    'b1101);
        check_val("p21_pulses",    pulse_cnt,              1);

        // 4. release bounce: off 56..60, on 60..64, off from 64 -> held falls at 76
        pressed[2*4+1] = 1'b0;
        wait_to(60); pressed[2*4+1] = 1'b1;
        wait_to(64); pressed[2*4+1] = 1'b0;
        wait_to(72); check_val("rel_held_72", int'(kp_bus.key_held), 1);
        wait_to(75); check_val("rel_held_75", int'(kp_bus.key_held), 1);
        wait_to(76);
        check_val("rel_held_76", int'(kp_bus.key_held), 0);
        check_val("rel_col_76",  int'(kp_bus.col_n),    'b1101);
        check_val("rel_pulses",  pulse_cnt,              1);
        // press (0,0): col 0 active after 88, detect 92, accept 100
        pressed[0] = 1'b1;
        wait_to(80); check_val("rel_resume_col", int'(kp_bus.col_n), 'b1011);
        wait_to(99); check_val("p00_pre_valid", int'(kp_bus.key_valid), 0);
        wait_to(100);
        check_val("p00_valid", int'(kp_bus.key_valid), 1);
        check_val("p00_code",  int'(kp_bus.key_code),  'b0000);
        check_val("p00_pulses", pulse_cnt, 2);
        wait_to(104); pressed[0] = 1'b0;
        wait_to(115); check_val("p00_held_115", int'(kp_bus.key_held), 1);
        wait_to(116);
        check_val("p00_held_116", int'(kp_bus.key_held), 0);
        check_val("p00_col_116",  int'(kp_bus.col_n),    'b1110);
        wait_to(120); check_val("p00_col_120", int'(kp_bus.col_n), 'b1101);

        // 3. bounce (1,3): col 3 after 128, detect 132, gone at 136 -> abort without rotation
        pressed[1*4+3] = 1'b1;
        wait_to(132); pressed[1*4+3] = 1'b0;
        check_val("bnc_col_132", int'(kp_bus.col_n), 'b0111);
        wait_to(136);
        check_val("bnc_col_136",  int'(kp_bus.col_n),    'b0111);
        check_val("bnc_held_136", int'(kp_bus.key_held), 0);
        wait_to(140);
        check_val("bnc_col_140", int'(kp_bus.col_n), 'b1110);
        check_val("bnc_pulses",  pulse_cnt,            2);

        // 5. multi-key (0,2)+(3,2): both rows low at col 2 tick 152 -> rotate on
        pressed[0*4+2] = 1'b1;
        pressed[3*4+2] = 1'b1;
        wait_to(152);
        check_val("mk_col_152", int'(kp_bus.col_n), 'b0111);
        pressed[0*4+2] = 1'b0;
        pressed[3*4+2] = 1'b0;
        wait_to(156);
        check_val("mk_col_156", int'(kp_bus.col_n),    'b1110);
        check_val("mk_held",    int'(kp_bus.key_held), 0);
        check_val("mk_pulses",  pulse_cnt,              2);

        // 6. press (3,0): detect 160, reset at 164 aborts, redo after release
        pressed[3*4+0] = 1'b1;
        wait_to(164);
        check_val("r6_col_frozen", int'(kp_bus.col_n), 'b1110);
        reset = 1'b0;
        wait_to(166);
        check_val("r6_col_n",     int'(kp_bus.col_n),     'b1110);
        check_val("r6_key_code",  int'(kp_bus.key_code),  0);
        check_val("r6_key_valid", int'(kp_bus.key_valid), 0);
        check_val("r6_key_held",  int'(kp_bus.key_held),  0);
        reset = 1'b1;
        wait_to(177);
        check_val("r6_pre_valid", int'(kp_bus.key_valid), 0);
        check_val("r6_no_abort_pulse", pulse_cnt, 2);
        wait_to(178);
        check_val("r6_valid", int'(kp_bus.key_valid), 1);
        check_val("r6_code",  int'(kp_bus.key_code),  'b1100);
        check_val("r6_held",  int'(kp_bus.key_held),  1);
        wait_to(180);
        check_val("r6_pulses", pulse_cnt, 3);

        // final reset while key held clears code and held flag
        reset = 1'b0;
        wait_to(182);
        check_val("fin_key_code", int'(kp_bus.key_code), 0);
        check_val("fin_key_held", int'(kp_bus.key_held), 0);
        check_val("fin_col_n",    int'(kp_bus.col_n),    'b1110);
        check_val("no_double_valid", dbl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
